// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle RV32I subset core (lw, sw, R/I-type ALU, beq/bne, lui).
// Optional illegal-opcode trap state enabled by defining MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int RETIRE_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  op,
    input  logic [2:0]                  funct3,
    input  logic                        funct7b5,
    input  logic                        zero,
    input  logic                        mem_ready,
    output logic                        pc_write,
    output logic                        adr_src,
    output logic                        mem_write,
    output logic                        ir_write,
    output logic [1:0]                  result_src,
    output logic [1:0]                  alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic [1:0]                  alu_op,
    output logic [1:0]                  imm_src,
    output logic                        reg_write,
    output logic                        instr_retired,
    output logic [RETIRE_CNT_WIDTH-1:0] retire_count,
    output logic                        illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_LUI
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // Moore part of the outputs, registered alongside the state they belong to.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       retire;
        logic       retire_on_ready;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    state_t                      r_state;
    ctrl_t                       r_ctrl;
    logic [RETIRE_CNT_WIDTH-1:0] r_retire_count;
    logic                        w_run;
    logic                        w_unused_inputs;

    function automatic state_t f_next(input state_t s, input logic [6:0] opc, input logic ready);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opc)
                    OP_LOAD, OP_STORE: n = S_MEMADR;
                    OP_RTYPE:          n = S_EXECR;
                    OP_ITYPE:          n = S_EXECI;
                    OP_BRANCH:         n = S_BRANCH;
                    OP_LUI:            n = S_LUI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:           n = S_TRAP;
`else
                    default:           n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   n = (opc == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: n = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    n = S_ALUWB;
            S_EXECI:    n = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     n = S_TRAP;
`endif
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t f_decode(input state_t s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            // ALUOut <= OldPC + B-immediate, ready for a possible branch.
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (opc == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src         = 1'b1;
                c.mem_write       = 1'b1;
                c.retire_on_ready = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            S_LUI: begin
                c.imm_src    = 2'b11;
                c.result_src = 2'b11;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: c.illegal = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_ctrl         <= f_decode(S_FETCH, op);
            r_retire_count <= '0;
        end else begin
            r_state <= f_next(r_state, op, mem_ready);
            r_ctrl  <= f_decode(f_next(r_state, op, mem_ready), op);
            if (instr_retired) begin
                r_retire_count <= r_retire_count + RETIRE_CNT_WIDTH'(1);
            end
        end
    end

    // Reset masks every control output so nothing is written while it is held.
    assign w_run = ~rst;

    assign pc_write      = w_run & ((r_ctrl.fetch & mem_ready) |
                                    (r_ctrl.branch & (zero ^ funct3[0])));
    assign ir_write      = w_run & r_ctrl.fetch & mem_ready;
    assign adr_src       = w_run & r_ctrl.adr_src;
    assign mem_write     = w_run & r_ctrl.mem_write;
    assign result_src    = w_run ? r_ctrl.result_src : 2'b00;
    assign alu_src_a     = w_run ? r_ctrl.alu_src_a  : 2'b00;
    assign alu_src_b     = w_run ? r_ctrl.alu_src_b  : 2'b00;
    assign alu_op        = w_run ? r_ctrl.alu_op     : 2'b00;
    assign imm_src       = w_run ? r_ctrl.imm_src    : 2'b00;
    assign reg_write     = w_run & r_ctrl.reg_write;
    assign instr_retired = w_run & (r_ctrl.retire | (r_ctrl.retire_on_ready & mem_ready));
    assign retire_count  = r_retire_count;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = w_run & r_ctrl.illegal;
`else
    assign illegal_instr = 1'b0;
`endif

    // funct7b5 and funct3[2:1] feed the ALU decoder, not this FSM.
    assign w_unused_inputs = ^{funct7b5, funct3[2:1]};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors queued and compared.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  imm_src;
    logic        reg_write;
    logic        instr_retired;
    logic [31:0] retire_count;
    logic        illegal_instr;

    multicycle_ctrl #(.RETIRE_CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .instr_retired (instr_retired),
        .retire_count  (retire_count),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [16:0] ctl;
        logic [31:0] cnt;
    } sb_t;

    sb_t         sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [31:0] exp_cnt;
    logic        cnt_known;
    logic [16:0] act_ctl;

    assign act_ctl = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, alu_op, imm_src, reg_write, instr_retired, illegal_instr};

    function automatic logic [16:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] imm,
                                       input logic rw, input logic ret, input logic ill);
        return {pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw, ret, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic mr);
        return pk(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_decode();
        return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_memadr(input logic is_sw);
        return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, is_sw ? 2'b01 : 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_memread();
        return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_memwb();
        return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    endfunction
    function automatic logic [16:0] e_memwrite(input logic mr);
        return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, mr, 0);
    endfunction
    function automatic logic [16:0] e_execr();
        return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_execi();
        return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_aluwb();
        return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    endfunction
    function automatic logic [16:0] e_branch(input logic pcw);
        return pk(pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1, 0);
    endfunction
    function automatic logic [16:0] e_lui();
        return pk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1, 0);
    endfunction
    function automatic logic [16:0] e_trap();
        return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    endfunction

    // One clock: drive inputs, queue expectation, compare at negedge, advance.
    task automatic cyc(input string nm, input logic [16:0] e, input logic mr,
                       input logic z, input logic r);
        sb_t ent;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        sb_q.push_back('{nm, e, exp_cnt});
        @(negedge clk);
        ent = sb_q.pop_front();
        n_tests++;
        if (act_ctl !== ent.ctl) begin
            n_fail++;
            $display("FAIL %s ctl actual=%b required=%b", ent.name, act_ctl, ent.ctl);
        end
        if (cnt_known) begin
            n_tests++;
            if (retire_count !== ent.cnt) begin
                n_fail++;
                $display("FAIL %s retire_count actual=%0d required=%0d",
                         ent.name, retire_count, ent.cnt);
            end
        end
        if (r) begin
            exp_cnt   = 32'd0;
            cnt_known = 1'b1;
        end else if (e[1]) begin
            exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc("rst_c0", 17'd0, 1, 1, 1);
        cyc("rst_c1", 17'd0, 1, 1, 1);
    endtask

    task automatic test_rtype();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        cyc("r_fetch",  e_fetch(1), 1, 0, 0);
        cyc("r_decode", e_decode(), 1, 1, 0);
        cyc("r_execr",  e_execr(),  1, 1, 0);
        cyc("r_aluwb",  e_aluwb(),  1, 1, 0);
    endtask

    task automatic test_itype();
        op = 7'b0010011; funct3 = 3'b111; funct7b5 = 1'b0;
        cyc("i_fetch",  e_fetch(1), 1, 1, 0);
        cyc("i_decode", e_decode(), 1, 0, 0);
        cyc("i_execi",  e_execi(),  1, 1, 0);
        cyc("i_aluwb",  e_aluwb(),  1, 0, 0);
    endtask

    task automatic test_lw_stall();
        op = 7'b0000011; funct3 = 3'b010;
        cyc("lw_fetch",  e_fetch(1),    1, 0, 0);
        cyc("lw_decode", e_decode(),    1, 0, 0);
        cyc("lw_memadr", e_memadr(0),   1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("lw_memread_stall", e_memread(), 0, 1, 0);
        cyc("lw_memread", e_memread(),  1, 0, 0);
        cyc("lw_memwb",   e_memwb(),    1, 0, 0);
    endtask

    task automatic test_sw_stall();
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 2; i++) cyc("sw_fetch_stall", e_fetch(0), 0, 0, 0);
        cyc("sw_fetch",      e_fetch(1),    1, 0, 0);
        cyc("sw_decode",     e_decode(),    1, 0, 0);
        cyc("sw_memadr",     e_memadr(1),   1, 0, 0);
        cyc("sw_memwr_wait", e_memwrite(0), 0, 0, 0);
        cyc("sw_memwr_done", e_memwrite(1), 1, 0, 0);
    endtask

    task automatic test_branch();
        logic [2:0] f3_tab [6] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b110, 3'b111};
        logic       z_tab  [6] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
        logic       pcw_tab[6] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
        op = 7'b1100011;
        for (int i = 0; i < 6; i++) begin
            funct3 = f3_tab[i];
            cyc("br_fetch",  e_fetch(1),          1, ~z_tab[i], 0);
            cyc("br_decode", e_decode(),          1, ~z_tab[i], 0);
            cyc("br_branch", e_branch(pcw_tab[i]), 1, z_tab[i],  0);
        end
    endtask

    task automatic test_lui();
        op = 7'b0110111; funct3 = 3'b000;
        cyc("lui_fetch",  e_fetch(1), 1, 1, 0);
        cyc("lui_decode", e_decode(), 1, 1, 0);
        cyc("lui_exec",   e_lui(),    1, 1, 0);
    endtask

    task automatic test_sw_reset();
        op = 7'b0100011; funct3 = 3'b010;
        cyc("swr_fetch",  e_fetch(1),    1, 0, 0);
        cyc("swr_decode", e_decode(),    1, 0, 0);
        cyc("swr_memadr", e_memadr(1),   1, 0, 0);
        cyc("swr_memwr",  e_memwrite(0), 0, 0, 0);
        cyc("swr_rst",    17'd0,         1, 0, 1);
        cyc("swr_fetch2", e_fetch(1),    1, 0, 0);
        cyc("swr_decode2", e_decode(),   1, 0, 0);
        cyc("swr_memadr2", e_memadr(1),  1, 0, 0);
        cyc("swr_memwr2", e_memwrite(1), 1, 0, 0);
    endtask

    task automatic test_illegal();
        op = 7'b1111111; funct3 = 3'b000;
        cyc("ill_fetch",  e_fetch(1), 1, 1, 0);
        cyc("ill_decode", e_decode(), 1, 1, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) cyc("ill_trap", e_trap(), 1, 1, 0);
        cyc("ill_rst", 17'd0, 1, 0, 1);
        op = 7'b0110111;
        cyc("ill_fetch2", e_fetch(1), 1, 0, 0);
`else
        op = 7'b0110111;
        cyc("ill_fetch2", e_fetch(1), 1, 0, 0);
`endif
        cyc("ill_decode2", e_decode(), 1, 0, 0);
        cyc("ill_lui",     e_lui(),    1, 0, 0);
    endtask

    task automatic test_back_to_back();
        test_rtype();
        test_lui();
        test_itype();
        cyc("b2b_fetch", e_fetch(0), 0, 0, 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = 32'd0;
        cnt_known = 1'b0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        op        = 7'd0;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_stall();
        test_sw_stall();
        test_branch();
        test_lui();
        test_sw_reset();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Main control FSM for the multi-cycle RV32I core subset: `lw`, `sw`, R-type ALU, I-type ALU, `beq`/`bne`, `lui`.
- Sequences the shared datapath (PC, IR, register file, ALU, unified memory, immediate extender) one instruction at a time.
- Supplies `imm_src` to the immediate extender; stalls on a memory ready handshake.
- Counts retired instructions.

## Interface
Parameters:
- `RETIRE_CNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `op`  in  7  opcode, instr[6:0], from IR.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30]; forwarded for ALU decode only.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  IR/OldPC load enable.
- `result_src`  out  2  Result mux: 00 ALUOut, 01 mem data, 10 ALU result, 11 ImmExt.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1.
- `alu_src_b`  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 decode by funct3/funct7b5.
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 U.
- `reg_write`  out  1  register file write enable.
- `instr_retired`  out  1  one-cycle pulse per completed instruction.
- `retire_count`  out  RETIRE_CNT_WIDTH  retired-instruction count.
- `illegal_instr`  out  1  trap flag; see Configuration.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, LUI, TRAP. TRAP exists only when the macro is defined.

Outputs are decoded from state (Moore). The only exceptions are the `mem_ready` and `zero` terms noted below. Any output not listed for a state is 0.

- FETCH:
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `imm_src`=10, `alu_op`=00. This precomputes the branch target into ALUOut.
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 0110111 → LUI; any other → illegal handling.
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - `imm_src` = 00 for `lw`, 01 for `sw`.
  - Next: MEMREAD for `lw`, MEMWRITE for `sw`.
- MEMREAD: `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Then FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=1. Held until `mem_ready`, then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Then ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00, `alu_op`=10. Then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Then FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`.
  - Then FETCH.
- LUI: `imm_src`=11, `result_src`=11, `reg_write`=1. Then FETCH.

Retirement:
- `instr_retired` is high in the final cycle of MEMWB, ALUWB, BRANCH, LUI, and in MEMWRITE when `mem_ready`=1.
- `retire_count` increments on the same edge.
- `retire_count` wraps modulo 2^RETIRE_CNT_WIDTH.

## Timing
Reset:
- When `rst` is high at an edge, state becomes FETCH and `retire_count` becomes 0.
- While `rst` is high, all control outputs and `instr_retired`/`illegal_instr` are forced to 0, so no writes occur during reset.
- `rst` asserted mid-instruction aborts the instruction without retiring it. A pending memory write is dropped.

Cycle counts, with zero-wait memory (`mem_ready` tied to 1):
- R-type, I-type: 4 cycles.
- `lui`, branch: 3 cycles.
- `sw`: 4 cycles.
- `lw`: 5 cycles.

Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. During a stall all outputs hold steady.

Branch outcome: `zero` is sampled in the BRANCH cycle only. `funct3` values other than 000/001 are treated by bit 0 alone.

## Configuration
Macro: `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - An unknown opcode in DECODE → TRAP.
  - TRAP asserts `illegal_instr`=1 with all writes 0.
  - The FSM stays in TRAP until `rst`. No retire.
- Undefined:
  - An unknown opcode in DECODE → FETCH (executes as a NOP, not retired).
  - TRAP does not exist; `illegal_instr` is tied to 0.

## Test plan
1. `rst` high for 2 cycles, then low with `mem_ready`=1 → all outputs 0 during reset; first post-reset cycle is FETCH with `pc_write`=`ir_write`=1; `retire_count`=0.
2. `op`=0110011, `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; `reg_write`=1 and `result_src`=00 only in cycle 4; `instr_retired` pulses once; `retire_count`=1.
3. `op`=0000011 with `mem_ready` low for 3 cycles in MEMREAD → `lw` takes 8 cycles; `imm_src`=00 in MEMADR; `adr_src`=1 held in MEMREAD; `reg_write` with `result_src`=01 in MEMWB.
4. `op`=1100011 with `funct3`=001 and `zero`=1, then `zero`=0 → `pc_write`=0 then 1 in BRANCH; `imm_src`=10 in DECODE.
5. `op`=0110111 → `imm_src`=11, `result_src`=11, `reg_write`=1 in cycle 3. Separately, `op`=0100011 with `rst` asserted in MEMWRITE → `mem_write` drops that cycle, state FETCH, no retire.
6. `op`=1111111 → with macro defined: TRAP, `illegal_instr`=1 held for ≥10 cycles until `rst`. Without macro: back to FETCH in cycle 3, `retire_count` unchanged.
